// File: rtl/rom_scanner_if.sv
// ROM access bus between the scanner (master) and a combinational ROM (slave).
interface rom_scanner_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] rom_addr;
   logic [DATA_WIDTH-1:0] rom_data;
   logic                  rom_illegal;

   modport master (output rom_addr, input rom_data, input rom_illegal);
   modport slave  (input rom_addr, output rom_data, output rom_illegal);
endinterface

// File: rtl/rom_scanner.sv
// Periodic ROM address scanner with wrap / one-shot / ping-pong sequencing.
//   state | meaning
//   IDLE  | waiting for an accepted start; outputs hold
//   RUN   | prescaler running, one ROM sample per tick
module rom_scanner #(
   parameter int ADDR_WIDTH      = 8,
   parameter int DATA_WIDTH      = 8,
   parameter int DIV             = 4,
   parameter bit STOP_ON_ILLEGAL = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic [1:0]            mode,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [ADDR_WIDTH-1:0] end_addr,
   input  logic [ADDR_WIDTH-1:0] step,
   rom_scanner_if.master         rom,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [ADDR_WIDTH-1:0] data_addr,
   output logic                  data_valid,
   output logic                  busy,
   output logic                  done,
   output logic                  cfg_err,
   output logic                  illegal_seen,
   output logic [ADDR_WIDTH-1:0] err_addr
);
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
   localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t                state_q, state_d;
   logic [1:0]            mode_q, mode_d;
   logic [ADDR_WIDTH-1:0] lo_q, lo_d, hi_q, hi_d, step_q, step_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  dir_q, dir_d;
   logic [PW-1:0]         presc_q, presc_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic [ADDR_WIDTH-1:0] data_addr_q, data_addr_d;
   logic                  data_valid_q, data_valid_d;
   logic                  done_q, done_d;
   logic                  cfg_err_q, cfg_err_d;
   logic                  ill_seen_q, ill_seen_d;
   logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

   logic [ADDR_WIDTH:0]   sum, diff;
   logic                  over, under, tick, finish, next_dir;
   logic [ADDR_WIDTH-1:0] next_addr;

   // Extra bit keeps addr+step and addr-step from wrapping silently.
   always_comb begin
      sum       = {1'b0, addr_q} + {1'b0, step_q};
      diff      = {1'b0, addr_q} - {1'b0, step_q};
      over      = sum > {1'b0, hi_q};
      under     = diff[ADDR_WIDTH] || (diff[ADDR_WIDTH-1:0] < lo_q);
      tick      = (state_q == RUN) && (presc_q == PRESC_LAST);
      finish    = 1'b0;
      next_addr = addr_q;
      next_dir  = dir_q;
      case (mode_q)
         2'b01: begin
            if (over) finish = 1'b1;
            else      next_addr = sum[ADDR_WIDTH-1:0];
         end
         2'b10: begin
            if (!dir_q) begin
               if (over) begin
                  next_dir  = 1'b1;
                  next_addr = under ? lo_q : diff[ADDR_WIDTH-1:0];
               end else begin
                  next_addr = sum[ADDR_WIDTH-1:0];
               end
            end else begin
               if (under) begin
                  next_dir  = 1'b0;
                  next_addr = over ? hi_q : sum[ADDR_WIDTH-1:0];
               end else begin
                  next_addr = diff[ADDR_WIDTH-1:0];
               end
            end
         end
         default: next_addr = over ? lo_q : sum[ADDR_WIDTH-1:0];
      endcase
      if (STOP_ON_ILLEGAL && rom.rom_illegal) finish = 1'b1;
   end

   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      lo_d         = lo_q;
      hi_d         = hi_q;
      step_d       = step_q;
      addr_d       = addr_q;
      dir_d        = dir_q;
      presc_d      = presc_q;
      data_out_d   = data_out_q;
      data_addr_d  = data_addr_q;
      data_valid_d = 1'b0;
      done_d       = 1'b0;
      cfg_err_d    = 1'b0;
      ill_seen_d   = ill_seen_q;
      err_addr_d   = err_addr_q;
      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               if (end_addr < start_addr) begin
                  cfg_err_d = 1'b1;
               end else begin
                  mode_d     = mode;
                  lo_d       = start_addr;
                  hi_d       = end_addr;
                  step_d     = (step == '0) ? ONE : step;
                  addr_d     = start_addr;
                  dir_d      = 1'b0;
                  ill_seen_d = 1'b0;
                  presc_d    = '0;
                  state_d    = RUN;
               end
            end
         end
         RUN: begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
               data_out_d   = rom.rom_data;
               data_addr_d  = addr_q;
               data_valid_d = 1'b1;
               if (rom.rom_illegal) begin
                  ill_seen_d = 1'b1;
                  if (!ill_seen_q) err_addr_d = addr_q;
               end
               if (finish) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  addr_d = next_addr;
                  dir_d  = next_dir;
               end
            end
            if (stop) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         mode_q       <= '0;
         lo_q         <= '0;
         hi_q         <= '0;
         step_q       <= '0;
         addr_q       <= '0;
         dir_q        <= 1'b0;
         presc_q      <= '0;
         data_out_q   <= '0;
         data_addr_q  <= '0;
         data_valid_q <= 1'b0;
         done_q       <= 1'b0;
         cfg_err_q    <= 1'b0;
         ill_seen_q   <= 1'b0;
         err_addr_q   <= '0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         lo_q         <= lo_d;
         hi_q         <= hi_d;
         step_q       <= step_d;
         addr_q       <= addr_d;
         dir_q        <= dir_d;
         presc_q      <= presc_d;
         data_out_q   <= data_out_d;
         data_addr_q  <= data_addr_d;
         data_valid_q <= data_valid_d;
         done_q       <= done_d;
         cfg_err_q    <= cfg_err_d;
         ill_seen_q   <= ill_seen_d;
         err_addr_q   <= err_addr_d;
      end
   end

   assign rom.rom_addr  = addr_q;
   assign data_out      = data_out_q;
   assign data_addr     = data_addr_q;
   assign data_valid    = data_valid_q;
   assign busy          = (state_q == RUN);
   assign done          = done_q;
   assign cfg_err       = cfg_err_q;
   assign illegal_seen  = ill_seen_q;
   assign err_addr      = err_addr_q;
endmodule

// File: tb/tb_rom_scanner.sv
// Three scanners (DIV=1, DIV=4, DIV=4 stop-on-illegal) share one stimulus and are checked against a sample-schedule model.
module tb_rom_scanner;
   localparam int N = 3;

   function automatic int div_of(input int i);
      return (i == 0) ? 1 : 4;
   endfunction

   function automatic bit soi_of(input int i);
      return (i == 2);
   endfunction

   function automatic logic [7:0] rom_val(input logic [7:0] a);
      return a * 8'd7 + 8'h3C;
   endfunction

   function automatic logic rom_ill(input logic [7:0] a, input logic en);
      return en && (a == 8'd6 || a == 8'd7);
   endfunction

   logic       clk, rst, start, stop, ill_en;
   logic [1:0] mode;
   logic [7:0] start_addr, end_addr, step;

   logic [7:0] d_out [N];
   logic [7:0] d_addr [N];
   logic [7:0] err_a [N];
   logic [7:0] r_addr [N];
   logic       d_valid [N];
   logic       busy [N];
   logic       done [N];
   logic       cfg_e [N];
   logic       ill [N];

   for (genvar g = 0; g < N; g++) begin : g_dut
      rom_scanner_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();
      assign bus.rom_data    = rom_val(bus.rom_addr);
      assign bus.rom_illegal = rom_ill(bus.rom_addr, ill_en);
      assign r_addr[g]       = bus.rom_addr;
      rom_scanner #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DIV(div_of(g)),
                    .STOP_ON_ILLEGAL(soi_of(g))) u_dut (
         .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
         .start_addr(start_addr), .end_addr(end_addr), .step(step),
         .rom(bus.master), .data_out(d_out[g]), .data_addr(d_addr[g]),
         .data_valid(d_valid[g]), .busy(busy[g]), .done(done[g]),
         .cfg_err(cfg_e[g]), .illegal_seen(ill[g]), .err_addr(err_a[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d] got=%0d exp=%0d t=%0t", nm, i, act, exp, $time);
      end
   endtask

   // Model: an active scan has a current address and the cycle of its next sample.
   int cyc = 0;
   bit m_act [N];
   int m_a [N], m_dir [N], m_s [N], m_e [N], m_st [N], m_mode [N], m_due [N];
   bit m_ill [N];
   int m_err [N], m_dout [N], m_daddr [N];
   bit m_valid [N], m_done [N], m_cfg [N];
   bit m_fin;
   int m_nxt;

   always @(posedge clk) begin
      cyc++;
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 0; m_done[i] = 0; m_cfg[i] = 0;
         if (rst) begin
            m_act[i] = 0; m_a[i] = 0; m_dir[i] = 0; m_ill[i] = 0;
            m_err[i] = 0; m_dout[i] = 0; m_daddr[i] = 0;
         end else if (!m_act[i]) begin
            if (start && !stop) begin
               if (end_addr < start_addr) m_cfg[i] = 1;
               else begin
                  m_act[i] = 1; m_s[i] = start_addr; m_e[i] = end_addr;
                  m_st[i] = (step == 0) ? 1 : int'(step); m_mode[i] = mode;
                  m_a[i] = start_addr; m_dir[i] = 0; m_ill[i] = 0;
                  m_due[i] = cyc + div_of(i);
               end
            end
         end else begin
            if (cyc == m_due[i]) begin
               m_valid[i] = 1; m_daddr[i] = m_a[i];
               m_dout[i] = int'(rom_val(8'(m_a[i])));
               m_fin = 0;
               if (rom_ill(8'(m_a[i]), ill_en)) begin
                  if (!m_ill[i]) m_err[i] = m_a[i];
                  m_ill[i] = 1;
                  if (soi_of(i)) m_fin = 1;
               end
               m_nxt = m_a[i];
               case (m_mode[i])
                  1: if (m_a[i] + m_st[i] > m_e[i]) m_fin = 1; else m_nxt = m_a[i] + m_st[i];
                  2: begin
                     if (m_dir[i] == 0) begin
                        if (m_a[i] + m_st[i] > m_e[i]) begin
                           m_dir[i] = 1;
                           m_nxt = (m_a[i] - m_st[i] < m_s[i]) ? m_s[i] : m_a[i] - m_st[i];
                        end else m_nxt = m_a[i] + m_st[i];
                     end else begin
                        if (m_a[i] - m_st[i] < m_s[i]) begin
                           m_dir[i] = 0;
                           m_nxt = (m_a[i] + m_st[i] > m_e[i]) ? m_e[i] : m_a[i] + m_st[i];
                        end else m_nxt = m_a[i] - m_st[i];
                     end
                  end
                  default: m_nxt = (m_a[i] + m_st[i] > m_e[i]) ? m_s[i] : m_a[i] + m_st[i];
               endcase
               if (m_fin) begin
                  m_done[i] = 1; m_act[i] = 0;
               end else begin
                  m_a[i] = m_nxt; m_due[i] = m_due[i] + div_of(i);
               end
            end
            if (stop) m_act[i] = 0;
         end
      end
   end

   int log_addr [N][$];
   int log_cyc [N][$];
   int done_cyc [N][$];
   int cfg_cnt [N];

   always @(posedge clk) begin
      #1;
      for (int i = 0; i < N; i++) begin
         chk("data_valid", i, 32'(d_valid[i]), 32'(m_valid[i]));
         chk("data_addr", i, 32'(d_addr[i]), 32'(m_daddr[i]));
         chk("data_out", i, 32'(d_out[i]), 32'(m_dout[i]));
         chk("done", i, 32'(done[i]), 32'(m_done[i]));
         chk("busy", i, 32'(busy[i]), 32'(m_act[i]));
         chk("cfg_err", i, 32'(cfg_e[i]), 32'(m_cfg[i]));
         chk("illegal_seen", i, 32'(ill[i]), 32'(m_ill[i]));
         chk("err_addr", i, 32'(err_a[i]), 32'(m_err[i]));
         if (m_act[i]) chk("rom_addr", i, 32'(r_addr[i]), 32'(m_a[i]));
         if (d_valid[i]) begin
            log_addr[i].push_back(int'(d_addr[i]));
            log_cyc[i].push_back(cyc);
         end
         if (done[i]) done_cyc[i].push_back(cyc);
         if (cfg_e[i]) cfg_cnt[i]++;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_cfg(input logic [1:0] m, input logic [7:0] s, input logic [7:0] e, input logic [7:0] st);
      @(negedge clk);
      mode = m; start_addr = s; end_addr = e; step = st;
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic pulse_stop();
      @(negedge clk); stop = 1'b1;
      @(negedge clk); stop = 1'b0;
   endtask

   task automatic clear_logs();
      for (int i = 0; i < N; i++) begin
         log_addr[i].delete(); log_cyc[i].delete(); done_cyc[i].delete(); cfg_cnt[i] = 0;
      end
   endtask

   int exp_wrap [6] = '{2, 3, 4, 5, 2, 3};
   int exp_pp [7]   = '{1, 4, 7, 4, 1, 4, 7};
   int exp_os [3]   = '{0, 4, 8};
   int budget;

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; ill_en = 1'b0;
      mode = 2'b00; start_addr = '0; end_addr = '0; step = '0;
      idle(3);
      for (int i = 0; i < N; i++) begin
         chk("rst_rom_addr", i, 32'(r_addr[i]), 0);
         chk("rst_busy", i, 32'(busy[i]), 0);
      end
      rst = 1'b0;

      // wrap, with a second start and config churn while running
      set_cfg(2'b00, 8'd2, 8'd5, 8'd1); clear_logs(); pulse_start();
      set_cfg(2'b10, 8'd7, 8'd9, 8'd3); pulse_start();
      idle(30); pulse_stop(); idle(3);
      for (int k = 0; k < 6; k++) chk("wrap_seq", 0, 32'(log_addr[0][k]), 32'(exp_wrap[k]));
      chk("wrap_gap", 0, 32'(log_cyc[0][1] - log_cyc[0][0]), 1);
      chk("wrap_stop_busy", 0, 32'(busy[0]), 0);

      // one-shot
      set_cfg(2'b01, 8'd0, 8'd9, 8'd4); clear_logs(); pulse_start();
      budget = 0;
      while ((busy[0] || busy[1] || busy[2]) && budget < 100) begin
         @(negedge clk); budget++;
      end
      chk("oneshot_timeout", 0, 32'(budget < 100), 1);
      idle(2);
      chk("oneshot_len", 1, 32'(log_addr[1].size()), 3);
      for (int k = 0; k < 3; k++) chk("oneshot_seq", 1, 32'(log_addr[1][k]), 32'(exp_os[k]));
      chk("oneshot_gap", 1, 32'(log_cyc[1][2] - log_cyc[1][1]), 4);
      chk("oneshot_done_cnt", 1, 32'(done_cyc[1].size()), 1);
      chk("oneshot_done_cyc", 1, 32'(done_cyc[1][0]), 32'(log_cyc[1][2]));

      // ping-pong
      set_cfg(2'b10, 8'd1, 8'd7, 8'd3); clear_logs(); pulse_start();
      idle(40); pulse_stop(); idle(3);
      for (int k = 0; k < 7; k++) chk("pp_seq", 0, 32'(log_addr[0][k]), 32'(exp_pp[k]));

      // degenerate range, step 0 treated as 1
      set_cfg(2'b10, 8'd3, 8'd3, 8'd0); clear_logs(); pulse_start();
      idle(8); pulse_stop(); idle(3);
      chk("pp_single_len", 0, 32'(log_addr[0].size() >= 3), 1);
      for (int k = 0; k < 3; k++) chk("pp_single_seq", 0, 32'(log_addr[0][k]), 3);

      set_cfg(2'b01, 8'd3, 8'd3, 8'd1); clear_logs(); pulse_start();
      idle(12);
      chk("os_single_len", 1, 32'(log_addr[1].size()), 1);
      chk("os_single_done", 1, 32'(done_cyc[1].size()), 1);

      // bad bounds
      set_cfg(2'b00, 8'd9, 8'd4, 8'd1); clear_logs(); pulse_start();
      idle(4);
      chk("cfg_err_cnt", 0, 32'(cfg_cnt[0]), 1);
      chk("cfg_err_nodata", 0, 32'(log_addr[0].size()), 0);
      chk("cfg_err_busy", 0, 32'(busy[0]), 0);

      // start and stop together
      set_cfg(2'b00, 8'd2, 8'd5, 8'd1); clear_logs();
      @(negedge clk); start = 1'b1; stop = 1'b1;
      @(negedge clk); start = 1'b0; stop = 1'b0;
      idle(3);
      chk("startstop_busy", 0, 32'(busy[0]), 0);
      chk("startstop_nodata", 0, 32'(log_addr[0].size()), 0);

      // illegal addresses 6 and 7
      ill_en = 1'b1;
      set_cfg(2'b00, 8'd4, 8'd9, 8'd1); clear_logs(); pulse_start();
      idle(40);
      chk("ill_seen", 0, 32'(ill[0]), 1);
      chk("ill_err_addr", 0, 32'(err_a[0]), 6);
      chk("ill_continue", 0, 32'(busy[0]), 1);
      chk("ill_err_addr", 1, 32'(err_a[1]), 6);
      chk("ill_stop_busy", 2, 32'(busy[2]), 0);
      chk("ill_stop_last", 2, 32'(log_addr[2][log_addr[2].size()-1]), 6);
      chk("ill_stop_done", 2, 32'(done_cyc[2].size()), 1);
      chk("ill_stop_done_cyc", 2, 32'(done_cyc[2][0]), 32'(log_cyc[2][log_cyc[2].size()-1]));
      pulse_stop(); ill_en = 1'b0; idle(3);

      // reset mid-scan
      set_cfg(2'b10, 8'd1, 8'd7, 8'd3); clear_logs(); pulse_start();
      idle(9);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < N; i++) begin
         chk("rstmid_busy", i, 32'(busy[i]), 0);
         chk("rstmid_valid", i, 32'(d_valid[i]), 0);
         chk("rstmid_done", i, 32'(done[i]), 0);
         chk("rstmid_data_out", i, 32'(d_out[i]), 0);
         chk("rstmid_data_addr", i, 32'(d_addr[i]), 0);
         chk("rstmid_rom_addr", i, 32'(r_addr[i]), 0);
         chk("rstmid_ill", i, 32'(ill[i]), 0);
         chk("rstmid_err_addr", i, 32'(err_a[i]), 0);
         chk("rstmid_cfg_err", i, 32'(cfg_e[i]), 0);
      end
      idle(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/rom_scanner.md
ROM_SCANNER -- requirements
Module: rom_scanner

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, the ROM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, the ROM data width.
REQ-003 SHALL have parameter DIV, default 4, the sample period in clk cycles (legal range DIV>=1).
REQ-004 SHALL have parameter STOP_ON_ILLEGAL, default 0; when 1, the scan halts on an illegal address.
REQ-005 clk  in  1  single clock; all logic on posedge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  one-cycle request to begin a scan.
REQ-008 stop  in  1  one-cycle abort request.
REQ-009 mode  in  2  00 wrap, 01 one-shot, 10 ping-pong, 11 reserved (treated as wrap).
REQ-010 start_addr, end_addr  in  ADDR_WIDTH  inclusive scan bounds.
REQ-011 step  in  ADDR_WIDTH  address increment; a value of 0 is treated as 1.
REQ-012 rom_addr  out  ADDR_WIDTH  registered address to the combinational ROM.
REQ-013 rom_data  in  DATA_WIDTH; rom_illegal  in  1; both driven combinationally from rom_addr.
REQ-014 data_out  out  DATA_WIDTH; data_addr  out  ADDR_WIDTH; data_valid  out  1  sample strobe.
REQ-015 busy  out  1; done  out  1 (pulse); cfg_err  out  1 (pulse).
REQ-016 illegal_seen  out  1 (sticky); err_addr  out  ADDR_WIDTH  first illegal address.

Function
REQ-017 SHALL implement the FSM states IDLE and RUN; busy SHALL be 1 exactly while the FSM is in RUN.
REQ-018 In IDLE, a start with stop=0 SHALL latch mode, start_addr, end_addr and step, set rom_addr to start_addr, set the direction to up, clear illegal_seen, clear the prescaler, and enter RUN.
REQ-019 A start with end_addr<start_addr SHALL be rejected: cfg_err pulses for 1 cycle and the FSM stays in IDLE.
REQ-020 When start and stop are both high in IDLE, the start SHALL be ignored.
REQ-021 While in RUN, start SHALL be ignored and configuration input changes SHALL have no effect.
REQ-022 The prescaler SHALL count 0..DIV-1 in RUN and assert tick when the count equals DIV-1; the first tick SHALL occur DIV cycles after the start is accepted.
REQ-023 On a tick, in the following cycle: data_out equals rom_data, data_addr equals the address sampled, data_valid equals 1 for one cycle, and rom_addr has advanced.
REQ-024 Next-address arithmetic SHALL be computed at ADDR_WIDTH+1 bits so that it never overflows silently.
REQ-025 Wrap mode: when addr+step>end_addr, next address = start_addr; otherwise next address = addr+step.
REQ-026 One-shot mode: when addr+step>end_addr, the tick SHALL emit its final sample, done SHALL pulse in the same cycle as that data_valid, and the FSM SHALL go to IDLE.
REQ-027 Ping-pong mode, direction up: on overshoot, the direction flips to down and next address = addr-step, saturated at start_addr.
REQ-028 Ping-pong mode, direction down: when addr-step<start_addr, the direction flips to up and next address = addr+step, saturated at end_addr.
REQ-029 When start_addr==end_addr, the address SHALL stay constant in wrap and ping-pong modes, and one-shot mode SHALL emit exactly one sample.
REQ-030 If rom_illegal=1 at a tick, the sample SHALL still be emitted; illegal_seen SHALL be set, and err_addr SHALL capture that address only if illegal_seen was 0.
REQ-031 With STOP_ON_ILLEGAL=1, an illegal tick SHALL additionally pulse done and return the FSM to IDLE.
REQ-032 A stop in RUN SHALL return the FSM to IDLE the next cycle, with no done pulse; a stop coinciding with a tick SHALL still emit that tick's sample.
REQ-033 In IDLE, rom_addr, data_out and data_addr SHALL hold their values.

Reset
REQ-034 rst SHALL take priority over all inputs.
REQ-035 On rst: FSM=IDLE, rom_addr=0, data_out=0, data_addr=0, data_valid=0, busy=0, done=0, cfg_err=0, illegal_seen=0, err_addr=0, prescaler=0, direction=up.
REQ-036 An rst asserted mid-scan SHALL abort the scan with no done and no data_valid in the reset cycle.

Verification
REQ-037 DIV=1, wrap mode, start=2, end=5, step=1 -> data_addr sequence 2,3,4,5,2,3…, with data_valid high every cycle.
REQ-038 DIV=4, one-shot mode, start=0, end=9, step=4 -> samples at addresses 0,4,8, 4 cycles apart, with done coincident with the sample at address 8, then busy=0.
REQ-039 Ping-pong mode, start=1, end=7, step=3 -> addresses 1,4,7,4,1,4,7…; and start=3, end=3 -> address 3 repeated.
REQ-040 start=9, end=4 -> cfg_err pulses once, busy stays 0, no data_valid.
REQ-041 rom_illegal forced at addresses 6 and 7, STOP_ON_ILLEGAL=0 -> illegal_seen=1, err_addr=6, scan continues; with STOP_ON_ILLEGAL=1 -> done after the sample at address 6, then busy=0.
REQ-042 stop, and separately rst, asserted mid-scan -> busy=0 next cycle, no done; after rst all outputs equal their REQ-035 values.
